// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control FSM: states, opcodes,
// funct codes and datapath select values.
package ctrl_pkg;

    localparam logic [4:0] S_RESET_SP  = 5'd0;
    localparam logic [4:0] S_FETCH     = 5'd1;
    localparam logic [4:0] S_FETCH_IR  = 5'd2;
    localparam logic [4:0] S_DECODE    = 5'd3;
    localparam logic [4:0] S_R_EXEC    = 5'd4;
    localparam logic [4:0] S_R_WB      = 5'd5;
    localparam logic [4:0] S_ADDI_EXEC = 5'd6;
    localparam logic [4:0] S_ADDI_WB   = 5'd7;
    localparam logic [4:0] S_MEM_ADDR  = 5'd8;
    localparam logic [4:0] S_LW_READ   = 5'd9;
    localparam logic [4:0] S_LW_WB     = 5'd10;
    localparam logic [4:0] S_SW_WRITE  = 5'd11;
    localparam logic [4:0] S_BRANCH    = 5'd12;
    localparam logic [4:0] S_JUMP      = 5'd13;
    localparam logic [4:0] S_EXC_EPC   = 5'd14;
    localparam logic [4:0] S_EXC_JUMP  = 5'd15;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;

    localparam logic [2:0] ALU_PASS = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_SUB  = 3'b010;
    localparam logic [2:0] ALU_AND  = 3'b011;

    localparam logic [1:0] PCS_ALU  = 2'b00;
    localparam logic [1:0] PCS_OUT  = 2'b01;
    localparam logic [1:0] PCS_JUMP = 2'b10;
    localparam logic [1:0] PCS_EXC  = 2'b11;

    localparam logic [1:0] IORD_PC  = 2'b00;
    localparam logic [1:0] IORD_ALU = 2'b01;
    localparam logic [1:0] IORD_EXC = 2'b10;

    localparam logic [1:0] SRCB_B   = 2'b00;
    localparam logic [1:0] SRCB_4   = 2'b01;
    localparam logic [1:0] SRCB_IMM = 2'b10;
    localparam logic [1:0] SRCB_SH2 = 2'b11;

    localparam logic [2:0] M2R_ALU = 3'b000;
    localparam logic [2:0] M2R_MDR = 3'b001;
    localparam logic [2:0] M2R_SP  = 3'b111;

    localparam logic [1:0] RDST_RT  = 2'b00;
    localparam logic [1:0] RDST_RD  = 2'b01;
    localparam logic [1:0] RDST_R29 = 2'b10;

    localparam logic [1:0] EXC_NONE  = 2'b00;
    localparam logic [1:0] EXC_UNDEF = 2'b01;
    localparam logic [1:0] EXC_OVF   = 2'b10;

    typedef struct packed {
        logic [1:0] i_or_d;
        logic [1:0] pc_source;
        logic       pc_write;
        logic       pc_write_cond;
        logic       branch_ne;
        logic       ir_write;
        logic       mdr_write;
        logic       a_b_write;
        logic       alu_out_write;
        logic       epc_write;
        logic       mem_write;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic [2:0] mem_to_reg;
        logic [1:0] reg_dst;
    } ctrl_out_t;

    function automatic logic is_alu_fn(input logic [5:0] fn);
        return (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_AND);
    endfunction

endpackage

// File: rtl/mem_wait_ctr.sv
// Memory wait-state counter: counts up from zero, done when it reaches LIMIT,
// cleared by the FSM when it leaves a waiting state.
module mem_wait_ctr #(
    parameter int unsigned       WAIT_W = 4,
    parameter logic [WAIT_W-1:0] LIMIT  = '0
) (
    input  logic clock,
    input  logic reset,
    input  logic clear_i,
    input  logic count_i,
    output logic done_o
);

    logic [WAIT_W-1:0] cnt_q;

    always_ff @(posedge clock) begin
        if (reset || clear_i) begin
            cnt_q <= '0;
        end else if (count_i) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign done_o = (cnt_q == LIMIT);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS control FSM: Moore decode of datapath enables/selects,
// configurable memory wait states and an optional exception sequence.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int unsigned MEM_WAIT = 1,
    parameter int unsigned WAIT_W   = 4,
    parameter bit          EN_EXC   = 1'b1,
    parameter int unsigned ALU_OP_W = 3
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [5:0]          op_code,
    input  logic [5:0]          funct,
    input  logic                overflow,
    output logic [1:0]          i_or_d,
    output logic [1:0]          pc_source,
    output logic                pc_write,
    output logic                pc_write_cond,
    output logic                branch_ne,
    output logic                ir_write,
    output logic                mdr_write,
    output logic                a_b_write,
    output logic                alu_out_write,
    output logic                epc_write,
    output logic                mem_write,
    output logic                reg_write,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic [2:0]          mem_to_reg,
    output logic [1:0]          reg_dst,
    output logic [1:0]          exc_cause,
    output logic [4:0]          state_dbg
);

    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_WAIT);

    logic [4:0] state_q, state_d;
    logic [1:0] exc_q, exc_d;
    logic       waiting, wait_done;
    ctrl_out_t  o;

    assign waiting = (state_q == S_FETCH) || (state_q == S_LW_READ);

    mem_wait_ctr #(
        .WAIT_W (WAIT_W),
        .LIMIT  (WAIT_LIMIT)
    ) u_wait (
        .clock   (clock),
        .reset   (reset),
        .clear_i (waiting && wait_done),
        .count_i (waiting && !wait_done),
        .done_o  (wait_done)
    );

    always_comb begin
        state_d = state_q;
        exc_d   = exc_q;
        case (state_q)
            S_RESET_SP: state_d = S_FETCH;
            S_FETCH:    if (wait_done) state_d = S_FETCH_IR;
            S_FETCH_IR: state_d = S_DECODE;
            S_DECODE: begin
                if (op_code == OP_RTYPE && is_alu_fn(funct)) begin
                    state_d = S_R_EXEC;
                end else if (op_code == OP_ADDI) begin
                    state_d = S_ADDI_EXEC;
                end else if (op_code == OP_LW || op_code == OP_SW) begin
                    state_d = S_MEM_ADDR;
                end else if (op_code == OP_BEQ || op_code == OP_BNE) begin
                    state_d = S_BRANCH;
                end else if (op_code == OP_J) begin
                    state_d = S_JUMP;
                end else if (EN_EXC) begin
                    state_d = S_EXC_EPC;
                    exc_d   = EXC_UNDEF;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_R_EXEC: begin
                // and cannot overflow, so it always writes back
                if (overflow && funct != FN_AND && EN_EXC) begin
                    state_d = S_EXC_EPC;
                    exc_d   = EXC_OVF;
                end else begin
                    state_d = S_R_WB;
                end
            end
            S_ADDI_EXEC: begin
                if (overflow && EN_EXC) begin
                    state_d = S_EXC_EPC;
                    exc_d   = EXC_OVF;
                end else begin
                    state_d = S_ADDI_WB;
                end
            end
            S_MEM_ADDR: state_d = (op_code == OP_LW) ? S_LW_READ : S_SW_WRITE;
            S_LW_READ:  if (wait_done) state_d = S_LW_WB;
            S_EXC_EPC:  state_d = S_EXC_JUMP;
            S_R_WB, S_ADDI_WB, S_LW_WB, S_SW_WRITE,
            S_BRANCH, S_JUMP, S_EXC_JUMP: state_d = S_FETCH;
            default:    state_d = S_RESET_SP;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_RESET_SP;
            exc_q   <= EXC_NONE;
        end else begin
            state_q <= state_d;
            exc_q   <= exc_d;
        end
    end

    always_comb begin
        o = '0;
        case (state_q)
            S_RESET_SP: begin
                o.reg_write  = 1'b1;
                o.mem_to_reg = M2R_SP;
                o.reg_dst    = RDST_R29;
            end
            S_FETCH: begin
                o.i_or_d    = IORD_PC;
                o.alu_src_b = SRCB_4;
                o.alu_op    = ALU_ADD;
            end
            S_FETCH_IR: begin
                o.ir_write  = 1'b1;
                o.pc_write  = 1'b1;
                o.pc_source = PCS_ALU;
                o.alu_src_b = SRCB_4;
                o.alu_op    = ALU_ADD;
            end
            S_DECODE: begin
                o.a_b_write     = 1'b1;
                o.alu_out_write = 1'b1;
                o.alu_src_b     = SRCB_SH2;
                o.alu_op        = ALU_ADD;
            end
            S_R_EXEC: begin
                o.alu_src_a     = 1'b1;
                o.alu_src_b     = SRCB_B;
                o.alu_out_write = 1'b1;
                case (funct)
                    FN_SUB:  o.alu_op = ALU_SUB;
                    FN_AND:  o.alu_op = ALU_AND;
                    default: o.alu_op = ALU_ADD;
                endcase
            end
            S_R_WB: begin
                o.reg_write  = 1'b1;
                o.reg_dst    = RDST_RD;
                o.mem_to_reg = M2R_ALU;
            end
            S_ADDI_EXEC, S_MEM_ADDR: begin
                o.alu_src_a     = 1'b1;
                o.alu_src_b     = SRCB_IMM;
                o.alu_op        = ALU_ADD;
                o.alu_out_write = 1'b1;
            end
            S_ADDI_WB: begin
                o.reg_write = 1'b1;
                o.reg_dst   = RDST_RT;
            end
            S_LW_READ: begin
                o.i_or_d    = IORD_ALU;
                o.mdr_write = wait_done;
            end
            S_LW_WB: begin
                o.reg_write  = 1'b1;
                o.reg_dst    = RDST_RT;
                o.mem_to_reg = M2R_MDR;
            end
            S_SW_WRITE: begin
                o.i_or_d    = IORD_ALU;
                o.mem_write = 1'b1;
            end
            S_BRANCH: begin
                o.alu_src_a     = 1'b1;
                o.alu_src_b     = SRCB_B;
                o.alu_op        = ALU_SUB;
                o.pc_source     = PCS_OUT;
                o.pc_write_cond = 1'b1;
                o.branch_ne     = (op_code == OP_BNE);
            end
            S_JUMP: begin
                o.pc_source = PCS_JUMP;
                o.pc_write  = 1'b1;
            end
            S_EXC_EPC: begin
                o.alu_src_b = SRCB_4;
                o.alu_op    = ALU_SUB;
                o.epc_write = 1'b1;
            end
            S_EXC_JUMP: begin
                o.pc_source = PCS_EXC;
                o.pc_write  = 1'b1;
            end
            default: o = '0;
        endcase
    end

    assign i_or_d        = o.i_or_d;
    assign pc_source     = o.pc_source;
    assign pc_write      = o.pc_write;
    assign pc_write_cond = o.pc_write_cond;
    assign branch_ne     = o.branch_ne;
    assign ir_write      = o.ir_write;
    assign mdr_write     = o.mdr_write;
    assign a_b_write     = o.a_b_write;
    assign alu_out_write = o.alu_out_write;
    assign epc_write     = o.epc_write;
    assign mem_write     = o.mem_write;
    assign reg_write     = o.reg_write;
    assign alu_src_a     = o.alu_src_a;
    assign alu_src_b     = o.alu_src_b;
    assign alu_op        = ALU_OP_W'(o.alu_op);
    assign mem_to_reg    = o.mem_to_reg;
    assign reg_dst       = o.reg_dst;
    assign exc_cause     = exc_q;
    assign state_dbg     = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: three instances (MEM_WAIT=1/2/0, the
// last with exceptions disabled) checked cycle by cycle against hand tables.
module tb_multicycle_ctrl;
    import ctrl_pkg::*;

    typedef logic [24:0] ov_t;

    localparam ov_t F_IORD_ALU = 25'd1 << 23;
    localparam ov_t F_PCS_OUT  = 25'd1 << 21;
    localparam ov_t F_PCS_J    = 25'd2 << 21;
    localparam ov_t F_PCS_EXC  = 25'd3 << 21;
    localparam ov_t F_PCW      = 25'd1 << 20;
    localparam ov_t F_PCWC     = 25'd1 << 19;
    localparam ov_t F_BNE      = 25'd1 << 18;
    localparam ov_t F_IRW      = 25'd1 << 17;
    localparam ov_t F_MDRW     = 25'd1 << 16;
    localparam ov_t F_ABW      = 25'd1 << 15;
    localparam ov_t F_AOW      = 25'd1 << 14;
    localparam ov_t F_EPCW     = 25'd1 << 13;
    localparam ov_t F_MEMW     = 25'd1 << 12;
    localparam ov_t F_REGW     = 25'd1 << 11;
    localparam ov_t F_SRCA     = 25'd1 << 10;
    localparam ov_t F_SRCB_4   = 25'd1 << 8;
    localparam ov_t F_SRCB_IMM = 25'd2 << 8;
    localparam ov_t F_SRCB_SH  = 25'd3 << 8;
    localparam ov_t F_ADD      = 25'd1 << 5;
    localparam ov_t F_SUB      = 25'd2 << 5;
    localparam ov_t F_AND      = 25'd3 << 5;
    localparam ov_t F_M2R_MDR  = 25'd1 << 2;
    localparam ov_t F_M2R_SP   = 25'd7 << 2;
    localparam ov_t F_RD       = 25'd1;
    localparam ov_t F_R29      = 25'd2;

    localparam ov_t O_RST   = F_REGW | F_M2R_SP | F_R29;
    localparam ov_t O_FETCH = F_SRCB_4 | F_ADD;
    localparam ov_t O_FIR   = F_SRCB_4 | F_ADD | F_IRW | F_PCW;
    localparam ov_t O_DEC   = F_ABW | F_AOW | F_SRCB_SH | F_ADD;
    localparam ov_t O_RADD  = F_SRCA | F_AOW | F_ADD;
    localparam ov_t O_RSUB  = F_SRCA | F_AOW | F_SUB;
    localparam ov_t O_RAND  = F_SRCA | F_AOW | F_AND;
    localparam ov_t O_RWB   = F_REGW | F_RD;
    localparam ov_t O_IEXEC = F_SRCA | F_SRCB_IMM | F_ADD | F_AOW;
    localparam ov_t O_IWB   = F_REGW;
    localparam ov_t O_LWR   = F_IORD_ALU;
    localparam ov_t O_LWRL  = F_IORD_ALU | F_MDRW;
    localparam ov_t O_LWWB  = F_REGW | F_M2R_MDR;
    localparam ov_t O_SW    = F_IORD_ALU | F_MEMW;
    localparam ov_t O_BEQ   = F_SRCA | F_SUB | F_PCS_OUT | F_PCWC;
    localparam ov_t O_BNE   = F_SRCA | F_SUB | F_PCS_OUT | F_PCWC | F_BNE;
    localparam ov_t O_J     = F_PCS_J | F_PCW;
    localparam ov_t O_EEPC  = F_SRCB_4 | F_SUB | F_EPCW;
    localparam ov_t O_EJ    = F_PCS_EXC | F_PCW;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] op_code = '0;
    logic [5:0] funct = '0;
    logic       overflow = 1'b0;

    logic [1:0] i_or_d [3];
    logic [1:0] pc_source [3];
    logic       pc_write [3];
    logic       pc_write_cond [3];
    logic       branch_ne [3];
    logic       ir_write [3];
    logic       mdr_write [3];
    logic       a_b_write [3];
    logic       alu_out_write [3];
    logic       epc_write [3];
    logic       mem_write [3];
    logic       reg_write [3];
    logic       alu_src_a [3];
    logic [1:0] alu_src_b [3];
    logic [2:0] alu_op [3];
    logic [2:0] mem_to_reg [3];
    logic [1:0] reg_dst [3];
    logic [1:0] exc_cause [3];
    logic [4:0] st [3];
    ov_t        ov [3];

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        multicycle_ctrl #(
            .MEM_WAIT ((g == 0) ? 1 : (g == 1) ? 2 : 0),
            .WAIT_W   (4),
            .EN_EXC   ((g == 2) ? 1'b0 : 1'b1),
            .ALU_OP_W (3)
        ) u_dut (
            .clock         (clock),
            .reset         (reset),
            .op_code       (op_code),
            .funct         (funct),
            .overflow      (overflow),
            .i_or_d        (i_or_d[g]),
            .pc_source     (pc_source[g]),
            .pc_write      (pc_write[g]),
            .pc_write_cond (pc_write_cond[g]),
            .branch_ne     (branch_ne[g]),
            .ir_write      (ir_write[g]),
            .mdr_write     (mdr_write[g]),
            .a_b_write     (a_b_write[g]),
            .alu_out_write (alu_out_write[g]),
            .epc_write     (epc_write[g]),
            .mem_write     (mem_write[g]),
            .reg_write     (reg_write[g]),
            .alu_src_a     (alu_src_a[g]),
            .alu_src_b     (alu_src_b[g]),
            .alu_op        (alu_op[g]),
            .mem_to_reg    (mem_to_reg[g]),
            .reg_dst       (reg_dst[g]),
            .exc_cause     (exc_cause[g]),
            .state_dbg     (st[g])
        );
        assign ov[g] = {i_or_d[g], pc_source[g], pc_write[g], pc_write_cond[g],
                        branch_ne[g], ir_write[g], mdr_write[g], a_b_write[g],
                        alu_out_write[g], epc_write[g], mem_write[g], reg_write[g],
                        alu_src_a[g], alu_src_b[g], alu_op[g], mem_to_reg[g], reg_dst[g]};
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input int k, input string tag, input logic [4:0] es, input ov_t eo);
        checks++;
        assert (st[k] === es) else begin
            errors++;
            $error("FAIL %s u%0d state observed=%0d expected=%0d", tag, k, st[k], es);
        end
        checks++;
        assert (ov[k] === eo) else begin
            errors++;
            $error("FAIL %s u%0d outputs observed=%h expected=%h", tag, k, ov[k], eo);
        end
    endtask

    task automatic chk_exc(input int k, input string tag, input logic [1:0] ee);
        checks++;
        assert (exc_cause[k] === ee) else begin
            errors++;
            $error("FAIL %s u%0d exc_cause observed=%b expected=%b", tag, k, exc_cause[k], ee);
        end
    endtask

    task automatic do_reset(input int k);
        reset = 1'b1;
        tick();
        tick();
        chk(k, "reset", S_RESET_SP, O_RST);
        chk_exc(k, "reset_exc", 2'b00);
        reset = 1'b0;
    endtask

    // FETCH for mw+1 cycles, then FETCH_IR and DECODE
    task automatic front(input int k, input int mw, input string tag);
        for (int i = 0; i <= mw; i++) begin
            tick();
            chk(k, {tag, "_fetch"}, S_FETCH, O_FETCH);
        end
        tick(); chk(k, {tag, "_fetch_ir"}, S_FETCH_IR, O_FIR);
        tick(); chk(k, {tag, "_decode"}, S_DECODE, O_DEC);
    endtask

    initial begin
        // instance 0: MEM_WAIT=1, exceptions enabled
        do_reset(0);
        op_code = OP_RTYPE; funct = FN_ADD; overflow = 1'b0;
        front(0, 1, "add");
        tick(); chk(0, "add_exec", S_R_EXEC, O_RADD);
        tick(); chk(0, "add_wb", S_R_WB, O_RWB);

        funct = FN_SUB; overflow = 1'b1;
        front(0, 1, "sub_ovf");
        tick(); chk(0, "sub_exec", S_R_EXEC, O_RSUB);
        tick(); chk(0, "sub_epc", S_EXC_EPC, O_EEPC);
        chk_exc(0, "sub_ovf_cause", 2'b10);
        tick(); chk(0, "sub_excj", S_EXC_JUMP, O_EJ);

        funct = FN_AND;
        front(0, 1, "and_ovf");
        tick(); chk(0, "and_exec", S_R_EXEC, O_RAND);
        tick(); chk(0, "and_wb", S_R_WB, O_RWB);
        chk_exc(0, "cause_hold", 2'b10);

        op_code = OP_ADDI; funct = 6'b000000;
        front(0, 1, "addi_ovf");
        tick(); chk(0, "addi_exec", S_ADDI_EXEC, O_IEXEC);
        tick(); chk(0, "addi_epc", S_EXC_EPC, O_EEPC);
        chk_exc(0, "addi_ovf_cause", 2'b10);
        tick(); chk(0, "addi_excj", S_EXC_JUMP, O_EJ);

        overflow = 1'b0;
        front(0, 1, "addi");
        tick(); chk(0, "addi_exec2", S_ADDI_EXEC, O_IEXEC);
        tick(); chk(0, "addi_wb", S_ADDI_WB, O_IWB);

        op_code = 6'b111111;
        front(0, 1, "undef");
        tick(); chk(0, "undef_epc", S_EXC_EPC, O_EEPC);
        chk_exc(0, "undef_cause", 2'b01);
        tick(); chk(0, "undef_excj", S_EXC_JUMP, O_EJ);

        op_code = OP_RTYPE; funct = FN_ADD; overflow = 1'b1;
        front(0, 1, "add_ovf2");
        tick(); chk(0, "add_exec2", S_R_EXEC, O_RADD);
        tick(); chk(0, "add_ovf_epc", S_EXC_EPC, O_EEPC);
        chk_exc(0, "add_ovf_cause", 2'b10);
        tick(); chk(0, "add_ovf_excj", S_EXC_JUMP, O_EJ);
        overflow = 1'b0;

        funct = 6'b000000;
        front(0, 1, "badfn");
        tick(); chk(0, "badfn_epc", S_EXC_EPC, O_EEPC);
        chk_exc(0, "badfn_cause", 2'b01);
        tick(); chk(0, "badfn_excj", S_EXC_JUMP, O_EJ);

        op_code = OP_BNE;
        front(0, 1, "bne");
        tick(); chk(0, "bne", S_BRANCH, O_BNE);
        op_code = OP_BEQ;
        front(0, 1, "beq");
        tick(); chk(0, "beq", S_BRANCH, O_BEQ);
        op_code = OP_J;
        front(0, 1, "j");
        tick(); chk(0, "j", S_JUMP, O_J);
        op_code = OP_SW;
        front(0, 1, "sw");
        tick(); chk(0, "sw_addr", S_MEM_ADDR, O_IEXEC);
        tick(); chk(0, "sw_write", S_SW_WRITE, O_SW);
        tick(); chk(0, "sw_done", S_FETCH, O_FETCH);

        // instance 1: MEM_WAIT=2
        do_reset(1);
        op_code = 6'b111111;
        front(1, 2, "u1_undef");
        tick(); chk(1, "u1_undef_epc", S_EXC_EPC, O_EEPC);
        chk_exc(1, "u1_undef_cause", 2'b01);
        tick(); chk(1, "u1_undef_excj", S_EXC_JUMP, O_EJ);

        op_code = OP_LW;
        front(1, 2, "lw");
        tick(); chk(1, "lw_addr", S_MEM_ADDR, O_IEXEC);
        tick(); chk(1, "lw_read1", S_LW_READ, O_LWR);
        tick(); chk(1, "lw_read2", S_LW_READ, O_LWR);
        tick(); chk(1, "lw_read3", S_LW_READ, O_LWRL);
        tick(); chk(1, "lw_wb", S_LW_WB, O_LWWB);

        front(1, 2, "lw_rst");
        tick(); chk(1, "lw_rst_addr", S_MEM_ADDR, O_IEXEC);
        tick(); chk(1, "lw_rst_read1", S_LW_READ, O_LWR);
        tick(); chk(1, "lw_rst_read2", S_LW_READ, O_LWR);
        reset = 1'b1;
        tick(); chk(1, "mid_reset", S_RESET_SP, O_RST);
        chk_exc(1, "mid_reset_exc", 2'b00);
        reset = 1'b0;
        front(1, 2, "after_rst");
        tick(); chk(1, "lw3_addr", S_MEM_ADDR, O_IEXEC);
        tick(); chk(1, "lw3_read1", S_LW_READ, O_LWR);
        tick(); chk(1, "lw3_read2", S_LW_READ, O_LWR);
        tick(); chk(1, "lw3_read3", S_LW_READ, O_LWRL);
        tick(); chk(1, "lw3_wb", S_LW_WB, O_LWWB);

        // instance 2: MEM_WAIT=0, exceptions disabled
        do_reset(2);
        op_code = 6'b111111;
        front(2, 0, "u2_undef");
        tick(); chk(2, "u2_undef_nop", S_FETCH, O_FETCH);
        chk_exc(2, "u2_undef_cause", 2'b00);
        op_code = OP_ADDI; overflow = 1'b1;
        tick(); chk(2, "u2_fetch_ir", S_FETCH_IR, O_FIR);
        tick(); chk(2, "u2_decode", S_DECODE, O_DEC);
        tick(); chk(2, "u2_addi_exec", S_ADDI_EXEC, O_IEXEC);
        tick(); chk(2, "u2_addi_wb", S_ADDI_WB, O_IWB);
        chk_exc(2, "u2_ovf_cause", 2'b00);
        overflow = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
